// File: rtl/modular_multiplier.sv
// Pipelined 30-bit modular multiplier: c = (a*b) mod q using Barrett reduction.
// The active (q, mu) pair is selected from a shared constant table and may only change while the pipe is empty.
module modular_multiplier #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mod_sel,
  input  logic [3:0]  mod_index,
  input  logic        in_valid,
  input  logic [29:0] a,
  input  logic [29:0] b,
  output logic        out_valid,
  output logic [29:0] c,
  output logic        busy
);

  // Every modulus must lie in [2^29, 2^30) so that the Barrett remainder stays below 3q.
  function automatic logic [29:0] table_q(input int idx);
    logic [29:0] q;
    case (idx)
      0:       q = 30'd998244353;
      1:       q = 30'd1004535809;
      2:       q = 30'd754974721;
      3:       q = 30'd1045430273;
      4:       q = 30'd1051721729;
      5:       q = 30'd1053818881;
      6:       q = 30'd1012924417;
      7:       q = 30'd1068564481;
      8:       q = 30'd985661441;
      9:       q = 30'd976224257;
      10:      q = 30'd975175681;
      11:      q = 30'd962592769;
      12:      q = 30'd950009857;
      13:      q = 30'd943718401;
      14:      q = 30'd935329793;
      default: q = 30'd1070727169;
    endcase
    return q;
  endfunction

  logic [29:0] q_rom  [16];
  logic [31:0] mu_rom [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rom
      localparam logic [29:0] Q    = table_q(gi);
      localparam logic [63:0] MU64 = (64'd1 << 60) / {34'd0, Q};
      assign q_rom[gi]  = Q;
      assign mu_rom[gi] = MU64[31:0];
    end
  endgenerate

  logic [LATENCY-1:0] v_reg;
  logic [29:0]        q_reg;
  logic [31:0]        mu_reg;

  logic [29:0] a_s1, b_s1;
  logic [59:0] p_s2;
  logic [31:0] p_s3;
  logic [30:0] qh_s3;
  logic [31:0] r_s4;

  logic [30:0] qh_next;
  logic [31:0] qm_lo;
  logic [31:0] r_next;
  logic [31:0] r1, r2;

  assign busy = |v_reg;

  // Only the low 32 bits of p - qh*q matter: the true remainder is below 3q < 2^32.
  assign qh_next = 31'((62'(p_s2[59:29]) * 62'(mu_reg)) >> 31);
  assign qm_lo   = 32'(qh_s3) * {2'b00, q_reg};
  assign r_next  = p_s3 - qm_lo;

  assign r1 = (r_s4 >= {2'b00, q_reg}) ? r_s4 - {2'b00, q_reg} : r_s4;
  assign r2 = (r1   >= {2'b00, q_reg}) ? r1   - {2'b00, q_reg} : r1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg     <= '0;
      q_reg     <= q_rom[0];
      mu_reg    <= mu_rom[0];
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      if (mod_sel && !busy) begin
        q_reg  <= q_rom[mod_index];
        mu_reg <= mu_rom[mod_index];
      end
      // A modulus strobe always swallows the operand presented with it.
      v_reg     <= {v_reg[LATENCY-2:0], in_valid & ~mod_sel};
      out_valid <= v_reg[LATENCY-1];
      if (v_reg[LATENCY-1]) begin
        c <= 30'(r2);
      end
    end
  end

  always_ff @(posedge clk) begin
    a_s1  <= a;
    b_s1  <= b;
    p_s2  <= 60'(a_s1) * 60'(b_s1);
    p_s3  <= p_s2[31:0];
    qh_s3 <= qh_next;
    r_s4  <= r_next;
  end

endmodule

// File: tb/tb_modular_multiplier.sv
// Self-checking bench for modular_multiplier: cycle model with plain % arithmetic plus literal expectations.
module tb_modular_multiplier;

  localparam longint unsigned Q7 = 64'd1068564481;
  localparam longint unsigned Q0 = 64'd998244353;

  logic        clk;
  logic        rst_n;
  logic        mod_sel;
  logic [3:0]  mod_index;
  logic        in_valid;
  logic [29:0] a;
  logic [29:0] b;
  logic        out_valid;
  logic [29:0] c;
  logic        busy;

  int checks;
  int failures;
  bit run_cmp;
  longint unsigned got_q[$];

  modular_multiplier #(.LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .mod_sel(mod_sel), .mod_index(mod_index),
    .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .c(c), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint unsigned qsel(input logic [3:0] idx);
    return (idx == 4'd7) ? Q7 : Q0;
  endfunction

  // Reference: an accepted operand pair becomes (a*b)%q exactly four edges later.
  logic [3:0]      mv;
  longint unsigned mc [4];
  logic            mov;
  longint unsigned moc;
  longint unsigned mq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv  <= '0;
      mov <= 1'b0;
      moc <= 0;
      mq  <= Q0;
    end else begin
      mov <= mv[3];
      if (mv[3]) moc <= mc[3];
      mv    <= {mv[2:0], in_valid && !mod_sel};
      mc[3] <= mc[2];
      mc[2] <= mc[1];
      mc[1] <= mc[0];
      mc[0] <= (64'(a) * 64'(b)) % mq;
      if (mod_sel && mv == 4'd0) mq <= qsel(mod_index);
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, mov});
      chk("busy", {63'd0, busy}, {63'd0, |mv});
      chk("c", {34'd0, c}, moc);
      if (out_valid) got_q.push_back(64'(c));
    end
  end

  task automatic drive(input logic ms, input logic [3:0] idx, input logic iv,
                       input longint unsigned aa, input longint unsigned bb);
    @(negedge clk);
    #1;
    mod_sel   = ms;
    mod_index = idx;
    in_valid  = iv;
    a         = aa[29:0];
    b         = bb[29:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 0, 0);
  endtask

  task automatic check_lit(input string name, input longint unsigned exp);
    if (got_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s got=no_result expected=%0d", name, exp);
    end else begin
      chk(name, got_q.pop_front(), exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; run_cmp = 1'b0;
    rst_n = 1'b0; mod_sel = 1'b0; mod_index = 4'd0; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_c", {34'd0, c}, 64'd0);
    run_cmp = 1'b1;
    #1 rst_n = 1'b1;

    // First edge after reset accepts data under table entry 0.
    drive(1'b0, 4'd0, 1'b1, Q0 - 1, Q0 - 1);
    idle(6);
    check_lit("entry0_square", 1);

    drive(1'b1, 4'd7, 1'b0, 0, 0);
    drive(1'b0, 4'd0, 1'b1, 65536, 16305);
    idle(6);
    check_lit("load7", 1068564480);

    drive(1'b0, 4'd0, 1'b1, Q7 - 1, Q7 - 1);
    drive(1'b0, 4'd0, 1'b1, Q7 - 1, 2);
    drive(1'b0, 4'd0, 1'b1, 0, Q7 - 1);
    drive(1'b0, 4'd0, 1'b1, 2, 3);
    idle(6);
    check_lit("burst0", 1);
    check_lit("burst1", 1068564479);
    check_lit("burst2", 0);
    check_lit("burst3", 6);

    // Modulus strobe while busy must be ignored.
    drive(1'b0, 4'd0, 1'b1, Q7 - 1, Q7 - 1);
    drive(1'b1, 4'd0, 1'b0, 0, 0);
    drive(1'b0, 4'd0, 1'b1, Q7 - 1, 2);
    idle(6);
    check_lit("guard0", 1);
    check_lit("guard1", 1068564479);

    drive(1'b1, 4'd7, 1'b1, 2, 3);
    idle(6);
    chk("prio_no_out", 64'(got_q.size()), 0);

    // Reset with two items in flight.
    drive(1'b0, 4'd0, 1'b1, 5, 7);
    drive(1'b0, 4'd0, 1'b1, 9, 11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_c", {34'd0, c}, 64'd0);
    #1 rst_n = 1'b1;
    mod_sel = 1'b0; in_valid = 1'b0;
    idle(6);
    chk("midrst_no_stale", 64'(got_q.size()), 0);

    drive(1'b1, 4'd7, 1'b0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      drive(1'b0, 4'd0, ($urandom_range(0, 3) != 0),
            $urandom_range(0, 32'(Q7 - 1)), $urandom_range(0, 32'(Q7 - 1)));
    end
    idle(6);
    got_q.delete();

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
